// File: rtl/clk_mux_pkg.sv
// rtl/clk_mux_pkg.sv - shared types and constants for the clock failover controller
package clk_mux_pkg;

    typedef enum logic [2:0] {
        HOLD,
        LOCK,
        RUN,
        SWITCH,
        FAULT
    } failover_state_t;

    localparam logic SEL_PRIMARY   = 1'b0;
    localparam logic SEL_SECONDARY = 1'b1;

    // Switch counter stops at all-ones instead of wrapping back to zero
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/clk_persist_ctr.sv
// rtl/clk_persist_ctr.sv - consecutive-cycle persistence counter saturating at THRESH
module clk_persist_ctr #(
    parameter int unsigned THRESH = 4
) (
    input  logic clk_ref,
    input  logic reset_in,
    input  logic clr,
    input  logic cond,
    output logic hit
);

    localparam int unsigned     W        = $clog2(THRESH + 1);
    localparam logic [W-1:0]    THRESH_V = W'(THRESH);

    logic [W-1:0] cnt;

    // Count consecutive cycles of cond; any gap or explicit clear restarts from zero
    always_ff @(posedge clk_ref or posedge reset_in) begin
        if (reset_in) begin
            cnt <= '0;
        end else if (clr || !cond) begin
            cnt <= '0;
        end else if (cnt != THRESH_V) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit = (cnt == THRESH_V);

endmodule

// File: rtl/clk_sync_2ff.sv
// rtl/clk_sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module clk_sync_2ff (
    input  logic clk_ref,
    input  logic reset_in,
    input  logic async_in,
    output logic sync_out
);

    logic [1:0] sync_ff;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability
    always_ff @(posedge clk_ref or posedge reset_in) begin
        if (reset_in) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], async_in};
        end
    end

    assign sync_out = sync_ff[1];

endmodule

// File: rtl/clk_failover_ctrl.sv
// rtl/clk_failover_ctrl.sv - primary/secondary clock failover with MMCM reset sequencing
module clk_failover_ctrl #(
    parameter int unsigned SWITCH_HOLDOFF_CYCLES = 1000,
    parameter int unsigned RESET_PULSE_CYCLES    = 100,
    parameter int unsigned LOCK_TIMEOUT_CYCLES   = 1_000_000,
    parameter int unsigned RETURN_HOLDOFF_CYCLES = 100_000_000,
    parameter bit          REVERTIVE             = 1'b1
) (
    input  logic        clk_ref,
    input  logic        reset_in,
    input  logic        pri_stopped,
    input  logic        sec_stopped,
    input  logic        force_en,
    input  logic        force_sel,
    input  logic        mmcm_locked,
    output logic        clk_sel,
    output logic        mmcm_reset,
    output logic        active_ok,
    output logic        fault,
    output logic [15:0] switch_count
);

    import clk_mux_pkg::*;

    // One timer serves both the reset pulse and the lock wait, so size it for the longer one
    localparam int unsigned TMR_MAX = (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RESET_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] PULSE_LAST   = TW'(RESET_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

    failover_state_t state;
    failover_state_t next_state;
    logic [TW-1:0]   timer;

    logic locked_sync;
    logic sel_bad;
    logic oth_bad;
    logic state_chg;
    logic fail_hit;
    logic rev_hit;
    logic pri_ok_hit;
    logic sec_ok_hit;
    logic fault_pick;

    assign sel_bad    = (clk_sel == SEL_SECONDARY) ? sec_stopped : pri_stopped;
    assign oth_bad    = (clk_sel == SEL_SECONDARY) ? pri_stopped : sec_stopped;
    assign state_chg  = (next_state != state);
    assign fault_pick = pri_stopped ? SEL_SECONDARY : SEL_PRIMARY;

    clk_sync_2ff u_lock_sync (
        .clk_ref  (clk_ref),
        .reset_in (reset_in),
        .async_in (mmcm_locked),
        .sync_out (locked_sync)
    );

    clk_persist_ctr #(.THRESH(SWITCH_HOLDOFF_CYCLES)) u_fail_ctr (
        .clk_ref  (clk_ref),
        .reset_in (reset_in),
        .clr      (state_chg),
        .cond     (sel_bad),
        .hit      (fail_hit)
    );

    clk_persist_ctr #(.THRESH(RETURN_HOLDOFF_CYCLES)) u_rev_ctr (
        .clk_ref  (clk_ref),
        .reset_in (reset_in),
        .clr      (1'b0),
        .cond     (!pri_stopped && (clk_sel == SEL_SECONDARY)),
        .hit      (rev_hit)
    );

    clk_persist_ctr #(.THRESH(SWITCH_HOLDOFF_CYCLES)) u_pri_ok_ctr (
        .clk_ref  (clk_ref),
        .reset_in (reset_in),
        .clr      (state_chg),
        .cond     (!pri_stopped),
        .hit      (pri_ok_hit)
    );

    clk_persist_ctr #(.THRESH(SWITCH_HOLDOFF_CYCLES)) u_sec_ok_ctr (
        .clk_ref  (clk_ref),
        .reset_in (reset_in),
        .clr      (state_chg),
        .cond     (!sec_stopped),
        .hit      (sec_ok_hit)
    );

    // Next-state selection; RUN exits are checked in strict priority order
    always_comb begin
        next_state = state;
        case (state)
            HOLD: begin
                if (timer == PULSE_LAST) next_state = LOCK;
            end
            LOCK: begin
                if (locked_sync) begin
                    next_state = RUN;
                end else if (timer == TIMEOUT_LAST) begin
                    next_state = oth_bad ? FAULT : SWITCH;
                end
            end
            RUN: begin
                if (!locked_sync) begin
                    next_state = HOLD;
                end else if (fail_hit) begin
                    next_state = oth_bad ? FAULT : SWITCH;
                end else if (force_en && (force_sel != clk_sel) && !oth_bad) begin
                    next_state = SWITCH;
                end else if (REVERTIVE && !force_en && (clk_sel == SEL_SECONDARY) && rev_hit) begin
                    next_state = SWITCH;
                end
            end
            SWITCH: begin
                next_state = HOLD;
            end
            FAULT: begin
                if (pri_ok_hit || sec_ok_hit) next_state = HOLD;
            end
            default: begin
                next_state = HOLD;
            end
        endcase
    end

    // State, phase timer and registered outputs derived from the state being entered
    always_ff @(posedge clk_ref or posedge reset_in) begin
        if (reset_in) begin
            state        <= HOLD;
            timer        <= '0;
            clk_sel      <= SEL_PRIMARY;
            mmcm_reset   <= 1'b1;
            active_ok    <= 1'b0;
            fault        <= 1'b0;
            switch_count <= '0;
        end else begin
            state <= next_state;
            if (state_chg || !((state == HOLD) || (state == LOCK))) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            mmcm_reset <= (next_state == HOLD) || (next_state == SWITCH) || (next_state == FAULT);
            active_ok  <= (next_state == RUN);
            fault      <= (next_state == FAULT);
            if (state == SWITCH) begin
                clk_sel      <= ~clk_sel;
                switch_count <= sat_inc16(switch_count);
            end else if ((state == FAULT) && (next_state == HOLD)) begin
                clk_sel <= fault_pick;
                if (fault_pick != clk_sel) switch_count <= sat_inc16(switch_count);
            end
        end
    end

endmodule

// File: tb/tb_clk_failover_ctrl.sv
// tb/tb_clk_failover_ctrl.sv - scoreboard bench for clk_failover_ctrl against a run-length reference model
module tb_clk_failover_ctrl;

    localparam int H = 4;
    localparam int P = 3;
    localparam int T = 50;
    localparam int R = 20;

    localparam int M_HOLD   = 0;
    localparam int M_LOCK   = 1;
    localparam int M_RUN    = 2;
    localparam int M_SWITCH = 3;
    localparam int M_FAULT  = 4;

    logic        clk_ref     = 1'b0;
    logic        reset_in    = 1'b1;
    logic        pri_stopped = 1'b0;
    logic        sec_stopped = 1'b0;
    logic        force_en    = 1'b0;
    logic        force_sel   = 1'b0;
    logic        mmcm_locked = 1'b0;
    logic        clk_sel;
    logic        mmcm_reset;
    logic        active_ok;
    logic        fault;
    logic [15:0] switch_count;

    always #5 clk_ref = ~clk_ref;

    clk_failover_ctrl #(
        .SWITCH_HOLDOFF_CYCLES (H),
        .RESET_PULSE_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES   (T),
        .RETURN_HOLDOFF_CYCLES (R),
        .REVERTIVE             (1'b1)
    ) dut (
        .clk_ref      (clk_ref),
        .reset_in     (reset_in),
        .pri_stopped  (pri_stopped),
        .sec_stopped  (sec_stopped),
        .force_en     (force_en),
        .force_sel    (force_sel),
        .mmcm_locked  (mmcm_locked),
        .clk_sel      (clk_sel),
        .mmcm_reset   (mmcm_reset),
        .active_ok    (active_ok),
        .fault        (fault),
        .switch_count (switch_count)
    );

    typedef struct {
        logic        sel;
        logic        rst;
        logic        ok;
        logic        flt;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: phase, time spent in phase, and run lengths of each input level
    int m_state, m_tis, m_sel, m_cnt, sel_age;
    int pri_bad_run, sec_bad_run, pri_good_run, sec_good_run;
    int l1, l2;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.sel = 1'(m_sel);
        e.rst = (m_state == M_HOLD) || (m_state == M_SWITCH) || (m_state == M_FAULT);
        e.ok  = (m_state == M_RUN);
        e.flt = (m_state == M_FAULT);
        e.cnt = 16'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_state = M_HOLD; m_tis = 0; m_sel = 0; m_cnt = 0; sel_age = 0;
        pri_bad_run = 0; sec_bad_run = 0; pri_good_run = 0; sec_good_run = 0;
        l1 = 0; l2 = 0;
    endtask

    // One clock edge of the reference behaviour using the inputs currently driven
    task automatic model_step();
        int nxt, nsel, ncnt, lsync, oth_bad, sel_bad_run;
        lsync       = l2;
        oth_bad     = m_sel ? int'(pri_stopped) : int'(sec_stopped);
        sel_bad_run = m_sel ? sec_bad_run : pri_bad_run;
        nxt = m_state; nsel = m_sel; ncnt = m_cnt;
        case (m_state)
            M_HOLD:   if (m_tis + 1 >= P) nxt = M_LOCK;
            M_LOCK: begin
                if (lsync != 0) nxt = M_RUN;
                else if (m_tis + 1 >= T) nxt = oth_bad ? M_FAULT : M_SWITCH;
            end
            M_RUN: begin
                if (lsync == 0) nxt = M_HOLD;
                else if (min2(sel_bad_run, m_tis) >= H) nxt = oth_bad ? M_FAULT : M_SWITCH;
                else if (force_en && (int'(force_sel) != m_sel) && !oth_bad) nxt = M_SWITCH;
                else if (!force_en && m_sel == 1 && min2(pri_good_run, sel_age) >= R) nxt = M_SWITCH;
            end
            M_SWITCH: begin
                nsel = 1 - m_sel;
                ncnt = min2(m_cnt + 1, 65535);
                nxt  = M_HOLD;
            end
            default: begin
                if (min2(pri_good_run, m_tis) >= H || min2(sec_good_run, m_tis) >= H) begin
                    nxt  = M_HOLD;
                    nsel = pri_stopped ? 1 : 0;
                    if (nsel != m_sel) ncnt = min2(m_cnt + 1, 65535);
                end
            end
        endcase
        m_tis        = (nxt != m_state) ? 0 : m_tis + 1;
        sel_age      = (m_sel == 1 && nsel == 1) ? sel_age + 1 : 0;
        pri_bad_run  = pri_stopped ? pri_bad_run + 1 : 0;
        pri_good_run = pri_stopped ? 0 : pri_good_run + 1;
        sec_bad_run  = sec_stopped ? sec_bad_run + 1 : 0;
        sec_good_run = sec_stopped ? 0 : sec_good_run + 1;
        l2 = l1;
        l1 = int'(mmcm_locked);
        m_state = nxt; m_sel = nsel; m_cnt = ncnt;
        push_exp();
    endtask

    task automatic run(input logic p, input logic s, input logic fe, input logic fs,
                       input logic lk, input int n);
        for (int i = 0; i < n; i++) begin
            pri_stopped = p; sec_stopped = s; force_en = fe; force_sel = fs; mmcm_locked = lk;
            model_step();
            @(negedge clk_ref);
        end
    endtask

    task automatic do_reset(input int n);
        reset_in = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            push_exp();
            @(negedge clk_ref);
        end
        reset_in = 1'b0;
        model_reset();
    endtask

    // Monitor: every clock edge yields one registered output set to compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_ref);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("clk_sel",      clk_sel,      e.sel);
                check("mmcm_reset",   mmcm_reset,   e.rst);
                check("active_ok",    active_ok,    e.ok);
                check("fault",        fault,        e.flt);
                check("switch_count", switch_count, e.cnt);
            end
        end
    end

    initial begin
        // 1: reset, lock arrives 10 cycles later
        do_reset(2);
        run(0, 0, 0, 0, 0, 10);
        run(0, 0, 0, 0, 1, 10);
        // 2: short primary glitch, then a persistent one
        run(1, 0, 0, 0, 1, 3);
        run(0, 0, 0, 0, 1, 5);
        run(1, 0, 0, 0, 1, 6);
        // 3: primary good just short of the return holdoff, then long enough
        run(0, 0, 0, 0, 1, 13);
        run(1, 0, 0, 0, 1, 2);
        run(0, 0, 0, 0, 1, 30);
        // 4: both stopped, then secondary recovers
        run(1, 1, 0, 0, 1, 12);
        run(1, 0, 0, 0, 1, 12);
        // 5: lock never arrives, then both clocks stop during the lock wait
        do_reset(2);
        run(0, 0, 0, 0, 0, 60);
        run(1, 1, 0, 0, 0, 60);
        run(0, 0, 0, 0, 1, 20);
        // 6: forced selection of a stopped target, then a healthy one, reset mid-HOLD
        run(0, 1, 1, 1, 1, 10);
        run(0, 0, 1, 1, 1, 2);
        do_reset(2);
        run(0, 0, 1, 1, 1, 12);
        run(0, 0, 1, 1, 1, 40);
        // Randomised segments of held input levels
        for (int seg = 0; seg < 250; seg++) begin
            if ($urandom_range(0, 39) == 0) do_reset(1);
            run(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) != 0), int'($urandom_range(1, 30)));
        end
        repeat (2) @(posedge clk_ref);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
